// File: rtl/vx_cache_core_rsp_merge_pkg.sv
// Shared helpers for the cache core response merge block: index widths and
// modular bank-index arithmetic used by the picker and the merge scan.
package vx_cache_core_rsp_merge_pkg;

    // Width of an index into n items; a single item still gets a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/vx_rr_lead_picker.sv
// Rotating priority encoder: first asserted request at or after ptr, with
// wrap-around. Returns the winner as one-hot and as an index.
module vx_rr_lead_picker
    import vx_cache_core_rsp_merge_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = '0;
        for (int i = 0; i < N; i++) begin
            j = PW'(wrap_add(int'(ptr), i, N));
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/vx_cache_core_rsp_merge.sv
// Merges per-bank core responses that share a core tag into one registered
// multi-lane core response, with round-robin fairness across banks.
module vx_cache_core_rsp_merge
    import vx_cache_core_rsp_merge_pkg::*;
#(
    parameter  int NUM_BANKS      = 4,
    parameter  int NUM_REQUESTS   = 4,
    parameter  int WORD_SIZE      = 4,
    parameter  int CORE_TAG_WIDTH = 8,
    localparam int TID_W          = clog2_min1(NUM_REQUESTS),
    localparam int PTR_W          = clog2_min1(NUM_BANKS),
    localparam int WORD_W         = WORD_SIZE * 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_BANKS-1:0]                per_bank_core_rsp_valid,
    input  logic [NUM_BANKS*TID_W-1:0]          per_bank_core_rsp_tid,
    input  logic [NUM_BANKS*WORD_W-1:0]         per_bank_core_rsp_data,
    input  logic [NUM_BANKS*CORE_TAG_WIDTH-1:0] per_bank_core_rsp_tag,
    output logic [NUM_BANKS-1:0]                per_bank_core_rsp_ready,
    output logic [NUM_REQUESTS-1:0]             core_rsp_valid,
    output logic [NUM_REQUESTS*WORD_W-1:0]      core_rsp_data,
    output logic [CORE_TAG_WIDTH-1:0]           core_rsp_tag,
    input  logic                                core_rsp_ready
);

    logic [NUM_BANKS-1:0][TID_W-1:0]          bank_tid;
    logic [NUM_BANKS-1:0][WORD_W-1:0]         bank_data;
    logic [NUM_BANKS-1:0][CORE_TAG_WIDTH-1:0] bank_tag;

    assign bank_tid  = per_bank_core_rsp_tid;
    assign bank_data = per_bank_core_rsp_data;
    assign bank_tag  = per_bank_core_rsp_tag;

    logic [NUM_REQUESTS-1:0]              valid_q, valid_d;
    logic [NUM_REQUESTS-1:0][WORD_W-1:0]  data_q, data_d;
    logic [CORE_TAG_WIDTH-1:0]            tag_q, tag_d;
    logic [PTR_W-1:0]                     ptr_q, ptr_d;

    logic [NUM_BANKS-1:0]                 lead_oh;
    logic [PTR_W-1:0]                     lead_idx;
    logic                                 lead_any;
    logic [CORE_TAG_WIDTH-1:0]            lead_tag;

    vx_rr_lead_picker #(.N(NUM_BANKS)) u_lead_picker (
        .req    (per_bank_core_rsp_valid),
        .ptr    (ptr_q),
        .onehot (lead_oh),
        .idx    (lead_idx),
        .any    (lead_any)
    );

    always_comb begin
        lead_tag = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            lead_tag = lead_tag | (bank_tag[b] & {CORE_TAG_WIDTH{lead_oh[b]}});
        end
    end

    // Scan from the lead so that on a lane conflict the bank nearest the
    // round-robin pointer wins and the others wait for a later cycle.
    logic [NUM_BANKS-1:0]                 merge;
    logic [NUM_REQUESTS-1:0]              claimed;
    logic [NUM_REQUESTS-1:0][WORD_W-1:0]  merge_data;
    logic [PTR_W-1:0]                     scan_b;
    logic [TID_W-1:0]                     lane;

    always_comb begin
        merge      = '0;
        claimed    = '0;
        merge_data = data_q;
        scan_b     = '0;
        lane       = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            scan_b = PTR_W'(wrap_add(int'(lead_idx), i, NUM_BANKS));
            lane   = (NUM_REQUESTS > 1) ? bank_tid[scan_b] : '0;
            if (lead_any && per_bank_core_rsp_valid[scan_b]
                && (bank_tag[scan_b] == lead_tag) && !claimed[lane]) begin
                merge[scan_b]    = 1'b1;
                claimed[lane]    = 1'b1;
                merge_data[lane] = bank_data[scan_b];
            end
        end
    end

    logic can_load;
    logic load;

    assign can_load = !(|valid_q) || core_rsp_ready;
    assign load     = can_load && lead_any;

    assign per_bank_core_rsp_ready = merge & {NUM_BANKS{can_load && reset}};

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = claimed;
            data_d  = merge_data;
            tag_d   = lead_tag;
            ptr_d   = PTR_W'(wrap_add(int'(lead_idx), 1, NUM_BANKS));
        end else if (core_rsp_ready) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            ptr_q   <= ptr_d;
        end
    end

    assign core_rsp_valid = valid_q;
    assign core_rsp_data  = data_q;
    assign core_rsp_tag   = tag_q;

    // A bank left waiting must present the same response on the next cycle.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_stable
        assert property (@(posedge clk) disable iff (!reset)
            (per_bank_core_rsp_valid[b] && !per_bank_core_rsp_ready[b]) |=>
            ($stable(per_bank_core_rsp_valid[b]) && $stable(bank_tid[b])
             && $stable(bank_data[b]) && $stable(bank_tag[b])));
    end

endmodule
